lc3_control_out_driver: RTL and testbench

- Producer (transmitting end) of the control_out interface.
- Sequences the LC3 pipeline by generating the enables for updatePC, fetch, decode, execute and writeback.
- Drives the memory-access state (mem_state), operand bypass selects and branch-taken for the five-stage datapath.
- Sits beside the datapath and consumes instruction words plus completion and status flags from it.

---
 rtl/lc3_control_out_driver_pkg.sv | 97 +++++++++
 rtl/lc3_control_out_driver_if.sv | 38 +++
 rtl/lc3_control_out_driver_bypass.sv | 54 +++++
 rtl/lc3_control_out_driver.sv | 250 +++++++++++++++++++++++++
 tb/tb_lc3_control_out_driver.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/lc3_control_out_driver_pkg.sv
//------------------------------------------------------------------------------
// control_out_pkg_hdl
// Shared types and opcode classifiers for the LC3 control_out driver.
//   lc3_opcode_t  : the 16 LC3 opcodes (instruction bits [15:12])
//   mem_state_t   : memory-access sequencer state (READ/READ_IND/WRITE/IDLE)
//   fetch_state_t : fetch FSM state (RUN / BR_WAIT)
//   BR_BUBBLE_DEF : default number of fetch bubbles after a control-flow fetch
//------------------------------------------------------------------------------
package control_out_pkg_hdl;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3_opcode_t;

  typedef enum logic [1:0] {
    READ     = 2'd0,
    READ_IND = 2'd1,
    WRITE    = 2'd2,
    IDLE     = 2'd3
  } mem_state_t;

  typedef enum logic {
    FETCH_RUN     = 1'b0,
    FETCH_BR_WAIT = 1'b1
  } fetch_state_t;

  localparam int BR_BUBBLE_DEF   = 3;
  localparam int STALL_CNT_W_DEF = 16;

  // Opcodes that occupy the memory stage for one or more accesses.
  function automatic logic is_mem_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: r = 1'b1;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes whose result comes from memory (mem bypass sources).
  function automatic logic is_load_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_LD, OP_LDR, OP_LDI: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes whose result comes from the ALU (alu bypass sources).
  function automatic logic is_alu_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_AND, OP_NOT: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Control-flow opcodes that force fetch bubbles.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_BR, OP_JMP: r = 1'b1;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  // First memory-sequencer state for a memory opcode.
  function automatic mem_state_t first_mem_state(input logic [3:0] op);
    mem_state_t r;
    case (op)
      OP_LD, OP_LDR:  r = READ;
      OP_LDI, OP_STI: r = READ_IND;
      OP_ST, OP_STR:  r = WRITE;
      default:        r = IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lc3_control_out_driver_if.sv
//------------------------------------------------------------------------------
// lc3_control_out_driver_if
// The control_out bundle from the pipeline controller to the LC3 datapath.
//   enable_*        : per-stage enables (updatePC, fetch, decode, execute, writeback)
//   br_taken        : select branch target for the PC
//   bypass_alu_1/2  : forward ALU result to operand 1/2
//   bypass_mem_1/2  : forward memory data to operand 1/2
//   mem_state       : 0 read, 1 indirect-address read, 2 write, 3 idle
// Modports: master (controller, drives), slave (datapath, receives).
//------------------------------------------------------------------------------
interface lc3_control_out_driver_if;
  import control_out_pkg_hdl::*;

  logic       enable_updatePC;
  logic       enable_fetch;
  logic       enable_decode;
  logic       enable_execute;
  logic       enable_writeback;
  logic       br_taken;
  logic       bypass_alu_1;
  logic       bypass_alu_2;
  logic       bypass_mem_1;
  logic       bypass_mem_2;
  logic [1:0] mem_state;

  modport master (
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );

  modport slave (
    input enable_updatePC, enable_fetch, enable_decode, enable_execute,
          enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
          bypass_mem_1, bypass_mem_2, mem_state
  );

endinterface

// File: rtl/lc3_control_out_driver_bypass.sv
//------------------------------------------------------------------------------
// lc3_bypass_detect
// Combinational operand-forwarding detection between the instruction in
// execute (producer) and the instruction in decode (consumer).
//   IR            in  16  instruction in decode
//   IR_Exec       in  16  instruction in execute
//   enable_decode in   1  decode enable; all bypasses are 0 while low
//   bypass_alu_1/2 out 1  forward ALU result to operand 1/2
//   bypass_mem_1/2 out 1  forward memory data to operand 1/2
//------------------------------------------------------------------------------
module lc3_bypass_detect
  import control_out_pkg_hdl::*;
(
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic        enable_decode,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic alu_src_s;
  logic ld_src_s;
  logic src1_hit_s;
  logic src2_hit_s;
  logic unused_bits_s;

  // Register compares; operand 2 forwards only for register-mode ADD/AND and
  // additionally requires the operand-1 match.
  always_comb begin
    alu_src_s  = is_alu_op(IR_Exec[15:12]);
    ld_src_s   = is_load_op(IR_Exec[15:12]);
    src1_hit_s = (IR_Exec[11:9] == IR[8:6]);
    src2_hit_s = src1_hit_s
               && ((IR[15:12] == OP_ADD) || (IR[15:12] == OP_AND))
               && (IR[5] == 1'b0)
               && (IR_Exec[11:9] == IR[2:0]);
    if (enable_decode) begin
      bypass_alu_1 = alu_src_s && src1_hit_s;
      bypass_alu_2 = alu_src_s && src2_hit_s;
      bypass_mem_1 = ld_src_s && src1_hit_s;
      bypass_mem_2 = ld_src_s && src2_hit_s;
    end else begin
      bypass_alu_1 = 1'b0;
      bypass_alu_2 = 1'b0;
      bypass_mem_1 = 1'b0;
      bypass_mem_2 = 1'b0;
    end
  end

  assign unused_bits_s = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

endmodule

// File: rtl/lc3_control_out_driver.sv
//------------------------------------------------------------------------------
// lc3_control_out_driver
// Pipeline sequencer for the five-stage LC3: stage enables, memory-access
// sequencing, fetch bubbles after control flow, branch-taken and bypasses.
//   clock          in   1  pipeline clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   complete_data  in   1  memory stage finished the current access
//   complete_instr in   1  instruction memory returned IMem_dout
//   IMem_dout      in  16  instruction word being fetched
//   IR             in  16  instruction in decode
//   IR_Exec        in  16  instruction in execute
//   NZP            in   3  condition codes from writeback
//   co             master  control_out bundle (enables, br_taken, bypass, mem_state)
//   stall_count    out STALL_CNT_W  (only with CONTROL_OUT_STALL_CNT_EN)
// Optional feature macro: CONTROL_OUT_STALL_CNT_EN adds a saturating counter of
// cycles spent in a memory stall or a branch wait.
//------------------------------------------------------------------------------
module lc3_control_out_driver
  import control_out_pkg_hdl::*;
#(
  parameter int BR_BUBBLE   = BR_BUBBLE_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         complete_data,
  input  logic                         complete_instr,
  input  logic [15:0]                  IMem_dout,
  input  logic [15:0]                  IR,
  input  logic [15:0]                  IR_Exec,
  input  logic [2:0]                   NZP,
  lc3_control_out_driver_if.master     co
`ifdef CONTROL_OUT_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]       stall_count
`endif
);

  localparam int CNT_W = (BR_BUBBLE > 1) ? $clog2(BR_BUBBLE + 1) : 1;
  localparam logic [CNT_W-1:0] BUBBLE_LOAD = CNT_W'(BR_BUBBLE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // fill_q[0] = fetch/updatePC, [1] = decode, [2] = execute, [3] = writeback
  logic [3:0]       fill_q, fill_d;
  mem_state_t       mem_state_q, mem_state_d;
  logic             stall_done_q, stall_done_d;
  fetch_state_t     fetch_q, fetch_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             br_val_q, br_val_d;
  logic             br_taken_q, br_taken_d;

  logic mem_idle_s;
  logic mem_trigger_s;
  logic advance_s;
  logic fetch_next_s;
  logic br_now_s;
  logic br_calc_s;
  logic br_pick_s;
  logic leave_wait_s;
  logic unused_in_s;

  // Stall trigger and global advance qualifier. stall_done_q suppresses a
  // second trigger by the same (still held) instruction once its access ends.
  always_comb begin
    mem_idle_s    = (mem_state_q == IDLE);
    mem_trigger_s = mem_idle_s && fill_q[2] && !stall_done_q
                  && is_mem_op(IR_Exec[15:12]);
    advance_s     = mem_idle_s && !mem_trigger_s;
  end

  // Memory-access sequencer next state.
  always_comb begin
    mem_state_d  = mem_state_q;
    stall_done_d = stall_done_q;
    case (mem_state_q)
      IDLE: begin
        if (mem_trigger_s) begin
          mem_state_d = first_mem_state(IR_Exec[15:12]);
        end else if (advance_s) begin
          stall_done_d = 1'b0;
        end else begin
          stall_done_d = stall_done_q;
        end
      end
      READ_IND: begin
        // IR_Exec is held during the stall, so it still selects LDI vs STI.
        if (complete_data) begin
          mem_state_d = (IR_Exec[15:12] == OP_STI) ? WRITE : READ;
        end else begin
          mem_state_d = mem_state_q;
        end
      end
      READ, WRITE: begin
        if (complete_data) begin
          mem_state_d  = IDLE;
          stall_done_d = 1'b1;
        end else begin
          mem_state_d = mem_state_q;
        end
      end
      default: begin
        mem_state_d = IDLE;
      end
    endcase
  end

  // Fetch FSM next state; only moves on unstalled cycles.
  always_comb begin
    fetch_d  = fetch_q;
    bubble_d = bubble_q;
    case (fetch_q)
      FETCH_RUN: begin
        if (advance_s && fill_q[0] && is_ctrl_op(IMem_dout[15:12])) begin
          fetch_d  = FETCH_BR_WAIT;
          bubble_d = BUBBLE_LOAD;
        end else begin
          fetch_d = FETCH_RUN;
        end
      end
      FETCH_BR_WAIT: begin
        if (advance_s) begin
          if (bubble_q == CNT_ONE) begin
            fetch_d = FETCH_RUN;
          end else begin
            bubble_d = bubble_q - CNT_ONE;
          end
        end else begin
          fetch_d = FETCH_BR_WAIT;
        end
      end
      default: begin
        fetch_d = FETCH_RUN;
      end
    endcase
  end

  // Fetch FSM output: value shifted into the fill register for fetch/updatePC.
  always_comb begin
    fetch_next_s = (fetch_d == FETCH_RUN);
  end

  // Fill shift register: bubbles travel downstream, frozen while stalled.
  always_comb begin
    if (advance_s) begin
      fill_d = {fill_q[2:0], fetch_next_s};
    end else begin
      fill_d = fill_q;
    end
  end

  // Branch resolution: latch the decision while the branch is in execute and
  // present it on the first RUN cycle after the wait.
  always_comb begin
    br_now_s     = (fetch_q == FETCH_BR_WAIT) && advance_s && fill_q[2]
                 && is_ctrl_op(IR_Exec[15:12]);
    br_calc_s    = (IR_Exec[15:12] == OP_JMP) ? 1'b1 : |(IR_Exec[11:9] & NZP);
    br_pick_s    = br_now_s ? br_calc_s : br_val_q;
    leave_wait_s = (fetch_q == FETCH_BR_WAIT) && (fetch_d == FETCH_RUN);
    if (leave_wait_s) begin
      br_val_d   = 1'b0;
      br_taken_d = br_pick_s;
    end else if (advance_s) begin
      br_val_d   = br_pick_s;
      br_taken_d = 1'b0;
    end else begin
      br_val_d   = br_val_q;
      br_taken_d = br_taken_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q       <= 4'b0000;
      mem_state_q  <= IDLE;
      stall_done_q <= 1'b0;
      br_val_q     <= 1'b0;
      br_taken_q   <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      mem_state_q  <= mem_state_d;
      stall_done_q <= stall_done_d;
      br_val_q     <= br_val_d;
      br_taken_q   <= br_taken_d;
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_q  <= FETCH_RUN;
      bubble_q <= {CNT_W{1'b0}};
    end else begin
      fetch_q  <= fetch_d;
      bubble_q <= bubble_d;
    end
  end

  // Outputs: enables and br_taken read as 0 while a memory access is pending.
  assign co.enable_updatePC  = fill_q[0] & mem_idle_s;
  assign co.enable_fetch     = fill_q[0] & mem_idle_s;
  assign co.enable_decode    = fill_q[1] & mem_idle_s;
  assign co.enable_execute   = fill_q[2] & mem_idle_s;
  assign co.enable_writeback = fill_q[3] & mem_idle_s;
  assign co.br_taken         = br_taken_q & mem_idle_s;
  assign co.mem_state        = mem_state_q;

  lc3_bypass_detect u_bypass (
    .IR            (IR),
    .IR_Exec       (IR_Exec),
    .enable_decode (fill_q[1] & mem_idle_s),
    .bypass_alu_1  (co.bypass_alu_1),
    .bypass_alu_2  (co.bypass_alu_2),
    .bypass_mem_1  (co.bypass_mem_1),
    .bypass_mem_2  (co.bypass_mem_2)
  );

`ifdef CONTROL_OUT_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   complete_instr_q;

  // Saturating count of memory-stall and branch-wait cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((mem_state_q != IDLE) || (fetch_q == FETCH_BR_WAIT))
        && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter and registered instruction-complete flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q      <= {STALL_CNT_W{1'b0}};
      complete_instr_q <= 1'b0;
    end else begin
      stall_cnt_q      <= stall_cnt_d;
      complete_instr_q <= complete_instr;
    end
  end

  assign stall_count = stall_cnt_q;
  assign unused_in_s = ^{IMem_dout[11:0], complete_instr_q};
`else
  assign unused_in_s = ^{IMem_dout[11:0], complete_instr};
`endif

endmodule

// File: tb/tb_lc3_control_out_driver.sv
module tb_lc3_control_out_driver;

  logic        clock;
  logic        reset;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
`ifdef CONTROL_OUT_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int checks_r;
  int errors_r;

  lc3_control_out_driver_if co_if ();

  lc3_control_out_driver dut (
    .clock          (clock),
    .reset          (reset),
    .complete_data  (complete_data),
    .complete_instr (complete_instr),
    .IMem_dout      (IMem_dout),
    .IR             (IR),
    .IR_Exec        (IR_Exec),
    .NZP            (NZP),
    .co             (co_if)
`ifdef CONTROL_OUT_STALL_CNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  logic [4:0] en_s;
  logic [3:0] byp_s;
  assign en_s  = {co_if.enable_updatePC, co_if.enable_fetch, co_if.enable_decode,
                  co_if.enable_execute, co_if.enable_writeback};
  assign byp_s = {co_if.bypass_alu_1, co_if.bypass_alu_2,
                  co_if.bypass_mem_1, co_if.bypass_mem_2};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic chk_en(input string tag, input logic [4:0] exp);
    check_eq(tag, {11'd0, en_s}, {11'd0, exp});
  endtask

  task automatic chk_ms(input string tag, input logic [1:0] exp);
    check_eq(tag, {14'd0, co_if.mem_state}, {14'd0, exp});
  endtask

  task automatic chk_br(input string tag, input logic exp);
    check_eq(tag, {15'd0, co_if.br_taken}, {15'd0, exp});
  endtask

  initial begin
    checks_r       = 0;
    errors_r       = 0;
    reset          = 1'b1;
    complete_data  = 1'b0;
    complete_instr = 1'b0;
    IMem_dout      = 16'h1000;
    IR             = 16'h1000;
    IR_Exec        = 16'h1E00;
    NZP            = 3'b000;
    tick; tick;

    // Reset state
    chk_en("rst_en", 5'b00000);
    chk_ms("rst_ms", 2'd3);
    chk_br("rst_br", 1'b0);
    check_eq("rst_byp", {12'd0, byp_s}, 16'h0000);

    // Pipeline fill
    reset = 1'b0;
    complete_instr = 1'b1;
    tick; chk_en("fill_c1", 5'b11000); chk_ms("fill_ms1", 2'd3);
    tick; chk_en("fill_c2", 5'b11100);
    tick; chk_en("fill_c3", 5'b11110);
    tick; chk_en("fill_c4", 5'b11111);

    // LDI stall, complete_data at +2 and +4
    IR_Exec = 16'hA000;
    #1; chk_ms("ldi_ms0", 2'd3);
    tick; chk_ms("ldi_ms1", 2'd1); chk_en("ldi_en1", 5'b00000);
    tick; chk_ms("ldi_ms2", 2'd1); chk_en("ldi_en2", 5'b00000);
    complete_data = 1'b1;
    tick; complete_data = 1'b0;
    chk_ms("ldi_ms3", 2'd0); chk_en("ldi_en3", 5'b00000);
    tick; chk_ms("ldi_ms4", 2'd0); chk_en("ldi_en4", 5'b00000);
    complete_data = 1'b1;
    tick; complete_data = 1'b0;
    chk_ms("ldi_ms5", 2'd3); chk_en("ldi_en5", 5'b11111);
    IR_Exec = 16'h1E00;

    // BR z with Z set: taken
    tick; chk_en("br_c0", 5'b11111);
    IMem_dout = 16'h0400; IR_Exec = 16'h0400; NZP = 3'b010;
    tick; chk_en("br_c1", 5'b00111); chk_br("br_b1", 1'b0);
    IMem_dout = 16'h1000;
    tick; chk_en("br_c2", 5'b00011);
    tick; chk_en("br_c3", 5'b00001); chk_br("br_b3", 1'b0);
    tick; chk_en("br_c4", 5'b11000); chk_br("br_b4", 1'b1);
    IR_Exec = 16'h1E00;
    tick; chk_en("br_c5", 5'b11100); chk_br("br_b5", 1'b0);

    // BR z with N set: not taken
    tick; tick; chk_en("nbr_c0", 5'b11111);
    IMem_dout = 16'h0400; IR_Exec = 16'h0400; NZP = 3'b100;
    tick; chk_en("nbr_c1", 5'b00111);
    IMem_dout = 16'h1000;
    tick; tick; tick; chk_en("nbr_c4", 5'b11000); chk_br("nbr_b4", 1'b0);
    IR_Exec = 16'h1E00;
    tick; tick; tick; chk_en("nbr_c7", 5'b11111);

    // Bypass detection
    IR_Exec = 16'h1600; IR = 16'h12C3;
    #1; check_eq("byp_alu", {12'd0, byp_s}, 16'h000C);
    IR = 16'h12E3;
    #1; check_eq("byp_alu_imm", {12'd0, byp_s}, 16'h0008);
    IR = 16'h12C3; IR_Exec = 16'h6600;
    #1; check_eq("byp_mem", {12'd0, byp_s}, 16'h0003);
    tick; chk_ms("ldr_ms", 2'd0); chk_en("ldr_en", 5'b00000);
    check_eq("byp_stall", {12'd0, byp_s}, 16'h0000);
    complete_data = 1'b1;
    tick; complete_data = 1'b0;
    chk_ms("ldr_ms_end", 2'd3); chk_en("ldr_en_end", 5'b11111);
    IR_Exec = 16'h1E00; IR = 16'h1000;

    // Reset during STI write phase
    tick; IR_Exec = 16'hB000;
    tick; chk_ms("sti_ms1", 2'd1);
    complete_data = 1'b1;
    tick; complete_data = 1'b0;
    chk_ms("sti_ms2", 2'd2);
    reset = 1'b1;
    tick; chk_ms("srst_ms", 2'd3); chk_en("srst_en", 5'b00000); chk_br("srst_br", 1'b0);
    reset = 1'b0; IR_Exec = 16'h1E00;
    tick; chk_en("srst_fill", 5'b11000);

`ifdef CONTROL_OUT_STALL_CNT_EN
    tick; tick;
    check_eq("cnt0", stall_count, 16'd0);
    IR_Exec = 16'h2000;
    tick; chk_ms("cnt_ld", 2'd0);
    tick; complete_data = 1'b1;
    tick; complete_data = 1'b0;
    IR_Exec = 16'h1E00; IMem_dout = 16'h0400;
    tick; IMem_dout = 16'h1000;
    tick; tick; tick;
    check_eq("cnt5", stall_count, 16'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
